// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register for the 5-stage MIPS core, plus the EX-stage
//   operand forwarding network that feeds the ALU.
//
//   The register stage captures every decoded field from D on each rising
//   clock edge. It has no enable. A D-stage stall is turned into a bubble
//   by the hazard unit driving clr. The forwarding network resolves RAW
//   hazards with the M and W results and then drives SrcA, SrcB and ALUOp.
//
// Ports
//   clk, reset           rising-edge clock; asynchronous active-high reset
//   clr                  load the NOP/bubble state on the next edge
//   D_pc .. D_tnew       decoded instruction fields from the D stage
//   M_wa/M_wd/M_fwd_ok   M-stage destination, result and result-valid flag
//   W_wa/W_wd            W-stage destination and result
//   E_pc, E_rs_addr,
//   E_rt_addr, E_wa,
//   E_tnew               registered E-stage fields exported to the hazard
//                        unit and to later stages
//   E_rt_fwd             forwarded rt value (store data for M)
//   SrcA, SrcB, ALUOp    ALU operands and operation
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter logic [3:0] BUBBLE_ALUOP = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic [31:0] D_pc,
    input  logic [31:0] D_rs_data,
    input  logic [31:0] D_rt_data,
    input  logic [31:0] D_ext32,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [4:0]  D_wa,
    input  logic [3:0]  D_aluop,
    input  logic        D_alusrc,
    input  logic [1:0]  D_tnew,
    input  logic [4:0]  M_wa,
    input  logic [31:0] M_wd,
    input  logic        M_fwd_ok,
    input  logic [4:0]  W_wa,
    input  logic [31:0] W_wd,
    output logic [31:0] E_pc,
    output logic [4:0]  E_rs_addr,
    output logic [4:0]  E_rt_addr,
    output logic [4:0]  E_wa,
    output logic [1:0]  E_tnew,
    output logic [31:0] E_rt_fwd,
    output logic [31:0] SrcA,
    output logic [31:0] SrcB,
    output logic [3:0]  ALUOp
);

    logic [31:0] pc_reg;
    logic [31:0] rs_data_reg;
    logic [31:0] rt_data_reg;
    logic [31:0] ext32_reg;
    logic [4:0]  rs_addr_reg;
    logic [4:0]  rt_addr_reg;
    logic [4:0]  wa_reg;
    logic [3:0]  aluop_reg;
    logic        alusrc_reg;
    logic [1:0]  tnew_reg;

    // The result gets one cycle closer while the instruction moves D -> E.
    // A value already at 0 saturates instead of wrapping around.
    logic [1:0]  tnew_next;
    assign tnew_next = (D_tnew == 2'd0) ? 2'd0 : D_tnew - 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg      <= '0;
            rs_data_reg <= '0;
            rt_data_reg <= '0;
            ext32_reg   <= '0;
            rs_addr_reg <= '0;
            rt_addr_reg <= '0;
            wa_reg      <= '0;
            aluop_reg   <= BUBBLE_ALUOP;
            alusrc_reg  <= 1'b0;
            tnew_reg    <= '0;
        end else if (clr) begin
            // The bubble has wa=0 and tnew=0, so it can never be a
            // forwarding source or a hazard producer.
            pc_reg      <= '0;
            rs_data_reg <= '0;
            rt_data_reg <= '0;
            ext32_reg   <= '0;
            rs_addr_reg <= '0;
            rt_addr_reg <= '0;
            wa_reg      <= '0;
            aluop_reg   <= BUBBLE_ALUOP;
            alusrc_reg  <= 1'b0;
            tnew_reg    <= '0;
        end else begin
            pc_reg      <= D_pc;
            rs_data_reg <= D_rs_data;
            rt_data_reg <= D_rt_data;
            ext32_reg   <= D_ext32;
            rs_addr_reg <= D_rs_addr;
            rt_addr_reg <= D_rt_addr;
            wa_reg      <= D_wa;
            aluop_reg   <= D_aluop;
            alusrc_reg  <= D_alusrc;
            tnew_reg    <= tnew_next;
        end
    end

    // Forwarding network. Index 0 is the rs operand and index 1 is the rt
    // operand; both use the same priority.
    //   $0      -> always reads 0 and is never forwarded
    //   M match -> used only when M's result is ready; otherwise the hazard
    //              unit stalls, so falling through to W/register is harmless
    //   W match -> W result
    //   else    -> value captured from the GRF in D
    logic [1:0][4:0]  src_addr;
    logic [1:0][31:0] src_data;
    logic [1:0][31:0] fwd_val;

    assign src_addr[0] = rs_addr_reg;
    assign src_addr[1] = rt_addr_reg;
    assign src_data[0] = rs_data_reg;
    assign src_data[1] = rt_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_val[gi] =
                (src_addr[gi] == 5'd0)                   ? 32'h0 :
                ((src_addr[gi] == M_wa) && M_fwd_ok)     ? M_wd  :
                (src_addr[gi] == W_wa)                   ? W_wd  :
                                                           src_data[gi];
        end
    endgenerate

    assign E_pc      = pc_reg;
    assign E_rs_addr = rs_addr_reg;
    assign E_rt_addr = rt_addr_reg;
    assign E_wa      = wa_reg;
    assign E_tnew    = tnew_reg;
    assign ALUOp     = aluop_reg;

    assign SrcA      = fwd_val[0];
    assign SrcB      = alusrc_reg ? ext32_reg : fwd_val[1];
    // Store data always needs the forwarded rt, even when the ALU takes
    // the immediate on SrcB.
    assign E_rt_fwd  = fwd_val[1];

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

    localparam logic [3:0] ALU_ADD = 4'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic [31:0] D_pc, D_rs_data, D_rt_data, D_ext32;
    logic [4:0]  D_rs_addr, D_rt_addr, D_wa;
    logic [3:0]  D_aluop;
    logic        D_alusrc;
    logic [1:0]  D_tnew;
    logic [4:0]  M_wa;
    logic [31:0] M_wd;
    logic        M_fwd_ok;
    logic [4:0]  W_wa;
    logic [31:0] W_wd;
    logic [31:0] E_pc, E_rt_fwd, SrcA, SrcB;
    logic [4:0]  E_rs_addr, E_rt_addr, E_wa;
    logic [1:0]  E_tnew;
    logic [3:0]  ALUOp;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.BUBBLE_ALUOP(4'd0)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .D_pc(D_pc), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
        .D_ext32(D_ext32), .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_wa(D_wa), .D_aluop(D_aluop), .D_alusrc(D_alusrc), .D_tnew(D_tnew),
        .M_wa(M_wa), .M_wd(M_wd), .M_fwd_ok(M_fwd_ok),
        .W_wa(W_wa), .W_wd(W_wd),
        .E_pc(E_pc), .E_rs_addr(E_rs_addr), .E_rt_addr(E_rt_addr),
        .E_wa(E_wa), .E_tnew(E_tnew), .E_rt_fwd(E_rt_fwd),
        .SrcA(SrcA), .SrcB(SrcB), .ALUOp(ALUOp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) begin
            $display("ok   %-14s obs=%08h exp=%08h", tag, obs, exp);
        end else begin
            mismatched++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- 1: reset holds NOP despite nonzero D and running clock
        reset = 1'b1; clr = 1'b0;
        D_pc = 32'h100; D_rs_data = 32'hAAAA; D_rt_data = 32'hBBBB; D_ext32 = 32'h7;
        D_rs_addr = 5'd3; D_rt_addr = 5'd4; D_wa = 5'd5; D_aluop = 4'd9;
        D_alusrc = 1'b0; D_tnew = 2'd2;
        M_wa = 5'd0; M_wd = 32'hDEAD; M_fwd_ok = 1'b0; W_wa = 5'd0; W_wd = 32'hBEEF;
        tick(); tick();
        check("rst_pc",     E_pc, 32'h0);
        check("rst_wa",     {27'b0, E_wa}, 32'h0);
        check("rst_rs",     {27'b0, E_rs_addr}, 32'h0);
        check("rst_tnew",   {30'b0, E_tnew}, 32'h0);
        check("rst_aluop",  {28'b0, ALUOp}, 32'h0);
        check("rst_srca",   SrcA, 32'h0);
        check("rst_srcb",   SrcB, 32'h0);
        check("rst_rtfwd",  E_rt_fwd, 32'h0);
        @(negedge clk); reset = 1'b0;
        tick();
        check("ld_pc",      E_pc, 32'h100);
        check("ld_wa",      {27'b0, E_wa}, 32'd5);
        check("ld_rt",      {27'b0, E_rt_addr}, 32'd4);
        check("ld_tnew",    {30'b0, E_tnew}, 32'd1);
        check("ld_aluop",   {28'b0, ALUOp}, 32'd9);
        check("ld_srca",    SrcA, 32'hAAAA);
        check("ld_srcb",    SrcB, 32'hBBBB);

        // ---- 2: immediate operand, no forwarding match
        D_rs_data = 32'd5; D_rt_data = 32'h1234; D_ext32 = 32'd7;
        D_alusrc = 1'b1; D_aluop = ALU_ADD;
        M_wa = 5'd9; M_fwd_ok = 1'b1; W_wa = 5'd10;
        tick();
        check("imm_srca",   SrcA, 32'd5);
        check("imm_srcb",   SrcB, 32'd7);
        check("imm_rtfwd",  E_rt_fwd, 32'h1234);
        check("imm_aluop",  {28'b0, ALUOp}, {28'b0, ALU_ADD});

        // ---- 3: M beats W; M not ready falls through to W, then register
        D_rs_addr = 5'd8; D_rs_data = 32'h33;
        tick();
        M_wa = 5'd8; M_wd = 32'h11; M_fwd_ok = 1'b1; W_wa = 5'd8; W_wd = 32'h22;
        #1 check("fwd_m_pri",  SrcA, 32'h11);
        M_fwd_ok = 1'b0;
        #1 check("fwd_m_nok",  SrcA, 32'h22);
        W_wa = 5'd1;
        #1 check("fwd_reg",    SrcA, 32'h33);

        // ---- 4: $0 never forwarded; rt forwarded from W when alusrc=0
        D_rt_addr = 5'd0; D_rt_data = 32'h55; D_alusrc = 1'b0;
        tick();
        M_wa = 5'd0; M_wd = 32'hFFFF; M_fwd_ok = 1'b1; W_wa = 5'd0; W_wd = 32'hFFFF;
        #1 check("zero_rtfwd", E_rt_fwd, 32'h0);
        check("zero_srcb",  SrcB, 32'h0);
        D_rt_addr = 5'd6; D_rt_data = 32'h66;
        tick();
        W_wa = 5'd6; W_wd = 32'h77; M_wa = 5'd2;
        #1 check("fwd_w_srcb", SrcB, 32'h77);
        check("fwd_w_rtfwd", E_rt_fwd, 32'h77);

        // ---- 5: clr inserts a bubble, then normal loading resumes
        M_wa = 5'd2; W_wa = 5'd1;
        D_rs_addr = 5'd3; D_rs_data = 32'h99; D_wa = 5'd7; D_tnew = 2'd2;
        D_aluop = 4'd5; D_pc = 32'h200; clr = 1'b1;
        tick();
        check("clr_wa",     {27'b0, E_wa}, 32'h0);
        check("clr_tnew",   {30'b0, E_tnew}, 32'h0);
        check("clr_srca",   SrcA, 32'h0);
        check("clr_srcb",   SrcB, 32'h0);
        check("clr_aluop",  {28'b0, ALUOp}, 32'h0);
        clr = 1'b0;
        tick();
        check("res_wa",     {27'b0, E_wa}, 32'd7);
        check("res_srca",   SrcA, 32'h99);
        check("res_pc",     E_pc, 32'h200);

        // ---- 6: Tnew saturating decrement, then async reset mid-cycle
        D_tnew = 2'd2; tick();
        check("tnew_2",     {30'b0, E_tnew}, 32'd1);
        D_tnew = 2'd1; tick();
        check("tnew_1",     {30'b0, E_tnew}, 32'd0);
        D_tnew = 2'd0; tick();
        check("tnew_0",     {30'b0, E_tnew}, 32'd0);
        D_tnew = 2'd2; tick();
        check("tnew_again", {30'b0, E_tnew}, 32'd1);
        #2 reset = 1'b1;
        #1 check("arst_tnew",  {30'b0, E_tnew}, 32'd0);
        check("arst_pc",    E_pc, 32'h0);
        check("arst_wa",    {27'b0, E_wa}, 32'h0);
        #2 reset = 1'b0;
        tick();
        check("post_tnew",  {30'b0, E_tnew}, 32'd1);
        check("post_pc",    E_pc, 32'h200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
